dac_output_stage: RTL

Downstream stage of the sine waveform generator: accepts 10-bit samples over a valid/ready handshake, buffers them in a small FIFO, and presents one sample per sample-rate tick on the 10 parallel DAC output pins. This decouples the generator's production rate from the fixed DAC update rate. Underflow holds the last value and is flagged.

---
 rtl/dac_pkg.sv | 10 +
 rtl/dac_output_stage_if.sv | 24 ++
 rtl/dac_output_stage_sample_fifo.sv | 64 ++++++
 rtl/dac_output_stage.sv | 91 +++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared constants and types for the DAC output path.
package dac_pkg;

    localparam int DAC_W = 10;

    localparam logic [DAC_W-1:0] DAC_MIDSCALE = 10'h200;

    typedef logic [DAC_W-1:0] dac_word_t;

endpackage

// File: rtl/dac_output_stage_if.sv
// Valid/ready sample bus into the DAC output stage.
interface dac_output_stage_if
    import dac_pkg::*;
#(
    parameter int DATA_W = DAC_W
);

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );

endinterface

// File: rtl/dac_output_stage_sample_fifo.sv
// Synchronous FIFO with occupancy count; depth must be a power of two.
module sample_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; validity is tracked by level alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/dac_output_stage.sv
// Buffers generator samples and updates the DAC word once per tick.
// Define DAC_SIGNED_IN_EN to accept two's-complement input samples.
module dac_output_stage
    import dac_pkg::*;
#(
    parameter int DATA_W     = DAC_W,
    parameter int FIFO_DEPTH = 8,
    parameter int TICK_DIV   = 12000,
    localparam int LW = $clog2(FIFO_DEPTH) + 1,
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dac_output_stage_if.slave   s,
    input  logic                clr_underflow,
    output logic [DATA_W-1:0]   dac_out,
    output logic                underflow,
    output logic [LW-1:0]       level
);

    localparam logic [DATA_W-1:0] MIDSCALE =
        {1'b1, {(DATA_W-1){1'b0}}};

    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0]     tick_cnt;
    logic              tick;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              fifo_full;
    logic              fifo_empty;

    // Ready follows reset combinationally so it drops the moment rst_n falls.
    assign s.s_ready = rst_n & ~fifo_full;
    assign push      = s.s_valid & s.s_ready;
    assign tick      = (tick_cnt == TICK_LAST);
    assign pop       = tick & ~fifo_empty;

`ifdef DAC_SIGNED_IN_EN
    assign wdata = {~s.s_data[DATA_W-1], s.s_data[DATA_W-2:0]};
`else
    assign wdata = s.s_data;
`endif

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_out <= MIDSCALE;
        end else if (pop) begin
            dac_out <= rdata;
        end
    end

    // An empty tick outranks a concurrent clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow <= 1'b0;
        end else if (tick && fifo_empty) begin
            underflow <= 1'b1;
        end else if (clr_underflow) begin
            underflow <= 1'b0;
        end
    end

endmodule
